// File: rtl/fp_mul_exp_pipe.sv
// rtl/fp_mul_exp_pipe.sv - two-stage sign/exponent/class datapath for the FP multiplier
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/ready   operand handshake (in_ready is combinational from out_ready)
//   mul1, mul2       IEEE-754 style operands, FP_WIDTH bits each
//   out_valid/ready  result handshake (out_valid is a register)
//   result_sign      sign of mul1 XOR sign of mul2
//   result_exp       signed biased exponent sum before normalisation
//   exp_ovf/exp_unf  result_exp >= all-ones exponent / result_exp <= 0
//   res_zero/inf/nan special-result class, at most one set
module fp_mul_exp_pipe #(
  parameter  int EXP_WIDTH  = 8,
  parameter  int MANT_WIDTH = 23,
  localparam int FP_WIDTH   = 1 + EXP_WIDTH + MANT_WIDTH,
  localparam int BIAS       = (1 << (EXP_WIDTH - 1)) - 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FP_WIDTH-1:0]         mul1,
  input  logic [FP_WIDTH-1:0]         mul2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        result_sign,
  output logic signed [EXP_WIDTH+1:0] result_exp,
  output logic                        exp_ovf,
  output logic                        exp_unf,
  output logic                        res_zero,
  output logic                        res_inf,
  output logic                        res_nan
);

  localparam int RW = EXP_WIDTH + 2;
  localparam logic signed [RW-1:0] BIAS_R  = RW'(BIAS);
  localparam logic signed [RW-1:0] OVF_LIM = RW'((1 << EXP_WIDTH) - 1);

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic nan;
  } cls_t;

  function automatic cls_t classify(input logic [EXP_WIDTH-1:0] e,
                                    input logic [MANT_WIDTH-1:0] m);
    cls_t c;
    c.zero = (e == '0) && (m == '0);
    c.sub  = (e == '0) && (m != '0);
    c.inf  = (e == '1) && (m == '0);
    c.nan  = (e == '1) && (m != '0);
    return c;
  endfunction

  // Zero and subnormal operands both use exponent 1; since e==0 there, forcing
  // bit 0 high yields exactly 1 without a full-width mux.
  function automatic logic [EXP_WIDTH-1:0] eff_exp(input logic [EXP_WIDTH-1:0] e,
                                                   input cls_t c);
    logic [EXP_WIDTH-1:0] r;
    r    = e;
    r[0] = e[0] | c.zero | c.sub;
    return r;
  endfunction

  // Field decode
  logic [EXP_WIDTH-1:0]  e1, e2;
  logic [MANT_WIDTH-1:0] m1, m2;
  cls_t                  c1, c2;

  assign e1 = mul1[FP_WIDTH-2 -: EXP_WIDTH];
  assign e2 = mul2[FP_WIDTH-2 -: EXP_WIDTH];
  assign m1 = mul1[MANT_WIDTH-1:0];
  assign m2 = mul2[MANT_WIDTH-1:0];
  assign c1 = classify(e1, m1);
  assign c2 = classify(e2, m2);

  // Stage registers
  logic                 s1_valid, s2_valid;
  logic                 s1_sign;
  logic [EXP_WIDTH-1:0] s1_eff1, s1_eff2;
  logic                 s1_zero1, s1_inf1, s1_nan1;
  logic                 s1_zero2, s1_inf2, s1_nan2;

  logic s1_load, s2_load;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // Stage-2 combinational results
  logic signed [RW-1:0] sum;
  logic                 nan_c, inf_c, zero_c;

  always_comb begin
    sum    = $signed({2'b00, s1_eff1}) + $signed({2'b00, s1_eff2}) - BIAS_R;
    // inf x zero is an invalid operation and therefore NaN
    nan_c  = s1_nan1 || s1_nan2 || (s1_inf1 && s1_zero2) || (s1_zero1 && s1_inf2);
    inf_c  = (s1_inf1 || s1_inf2) && !nan_c;
    zero_c = (s1_zero1 || s1_zero2) && !nan_c && !inf_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_eff1     <= '0;
      s1_eff2     <= '0;
      s1_zero1    <= 1'b0;
      s1_inf1     <= 1'b0;
      s1_nan1     <= 1'b0;
      s1_zero2    <= 1'b0;
      s1_inf2     <= 1'b0;
      s1_nan2     <= 1'b0;
      result_sign <= 1'b0;
      result_exp  <= '0;
      exp_ovf     <= 1'b0;
      exp_unf     <= 1'b0;
      res_zero    <= 1'b0;
      res_inf     <= 1'b0;
      res_nan     <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
      end
      if (in_valid && s1_load) begin
        s1_sign  <= mul1[FP_WIDTH-1] ^ mul2[FP_WIDTH-1];
        s1_eff1  <= eff_exp(e1, c1);
        s1_eff2  <= eff_exp(e2, c2);
        s1_zero1 <= c1.zero;
        s1_inf1  <= c1.inf;
        s1_nan1  <= c1.nan;
        s1_zero2 <= c2.zero;
        s1_inf2  <= c2.inf;
        s1_nan2  <= c2.nan;
      end

      if (s2_load) begin
        s2_valid <= s1_valid;
      end
      // Output registers move only on a stage-1 to stage-2 transfer, so they
      // hold steady while out_valid && !out_ready.
      if (s1_valid && s2_load) begin
        result_sign <= s1_sign;
        result_exp  <= sum;
        exp_ovf     <= (sum >= OVF_LIM);
        exp_unf     <= (sum <= 0);
        res_nan     <= nan_c;
        res_inf     <= inf_c;
        res_zero    <= zero_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_exp_pipe.sv
// tb/tb_fp_mul_exp_pipe.sv - directed self-checking bench for fp_mul_exp_pipe
module tb_fp_mul_exp_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Single-precision instance
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       mul1 = '0;
  logic [31:0]       mul2 = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              result_sign;
  logic signed [9:0] result_exp;
  logic              exp_ovf, exp_unf, res_zero, res_inf, res_nan;

  fp_mul_exp_pipe #(.EXP_WIDTH(8), .MANT_WIDTH(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mul1(mul1), .mul2(mul2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_sign(result_sign), .result_exp(result_exp),
    .exp_ovf(exp_ovf), .exp_unf(exp_unf),
    .res_zero(res_zero), .res_inf(res_inf), .res_nan(res_nan)
  );

  // Half-precision instance
  logic              h_in_valid = 1'b0;
  logic              h_in_ready;
  logic [15:0]       h_mul1 = '0;
  logic [15:0]       h_mul2 = '0;
  logic              h_out_valid;
  logic              h_out_ready = 1'b1;
  logic              h_result_sign;
  logic signed [6:0] h_result_exp;
  logic              h_exp_ovf, h_exp_unf, h_res_zero, h_res_inf, h_res_nan;

  fp_mul_exp_pipe #(.EXP_WIDTH(5), .MANT_WIDTH(10)) dut_h (
    .clk(clk), .rst(rst),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .mul1(h_mul1), .mul2(h_mul2),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result_sign(h_result_sign), .result_exp(h_result_exp),
    .exp_ovf(h_exp_ovf), .exp_unf(h_exp_unf),
    .res_zero(h_res_zero), .res_inf(h_res_inf), .res_nan(h_res_nan)
  );

  // flags order: {nan, inf, zero, ovf, unf}
  function automatic logic [31:0] pack(input logic s, input int e, input logic [4:0] f);
    logic [9:0] e10;
    e10 = 10'(e);
    return {16'b0, s, e10, f};
  endfunction

  function automatic logic [31:0] obs();
    return pack(result_sign, int'(result_exp),
                {res_nan, res_inf, res_zero, exp_ovf, exp_unf});
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int e, input logic [4:0] f);
    @(negedge clk);
    mul1 = a; mul2 = b; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, " lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk(tag, obs(), pack(s, e, f));
    @(negedge clk);
    #1 chk({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] bp_a [5];
  logic [31:0] bp_b [5];
  logic [31:0] bp_e [5];

  initial begin
    // Reset state
    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst payload", obs(), pack(1'b0, 0, 5'b0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // Directed single vectors
    run_vec("1.0x1.0",   32'h3F800000, 32'h3F800000, 1'b0, 127,  5'b00000);
    run_vec("2.0x-3.0",  32'h40000000, 32'hC0400000, 1'b1, 129,  5'b00000);
    run_vec("ovf",       32'h7F000000, 32'h7F000000, 1'b0, 381,  5'b00010);
    run_vec("unf",       32'h00800000, 32'h00800000, 1'b0, -125, 5'b00001);
    run_vec("sub",       32'h00000001, 32'h3F800000, 1'b0, 1,    5'b00000);
    run_vec("inf*zero",  32'h7F800000, 32'h00000000, 1'b0, 129,  5'b10000);
    run_vec("inf*1",     32'h7F800000, 32'h3F800000, 1'b0, 255,  5'b01010);
    run_vec("-0*1",      32'h80000000, 32'h3F800000, 1'b1, 1,    5'b00100);
    run_vec("nan*1",     32'h7FC00000, 32'h3F800000, 1'b0, 255,  5'b10010);

    // Backpressure: out_ready low for cycles 3..6
    bp_a[0] = 32'h3F800000; bp_b[0] = 32'h3F800000; bp_e[0] = pack(1'b0, 127,  5'b00000);
    bp_a[1] = 32'h40000000; bp_b[1] = 32'hC0400000; bp_e[1] = pack(1'b1, 129,  5'b00000);
    bp_a[2] = 32'h7F000000; bp_b[2] = 32'h7F000000; bp_e[2] = pack(1'b0, 381,  5'b00010);
    bp_a[3] = 32'h00800000; bp_b[3] = 32'h00800000; bp_e[3] = pack(1'b0, -125, 5'b00001);
    bp_a[4] = 32'h80000000; bp_b[4] = 32'h3F800000; bp_e[4] = pack(1'b1, 1,    5'b00100);
    begin
      int idx  = 0;
      int oidx = 0;
      for (int c = 0; c < 20 && oidx < 5; c++) begin
        @(negedge clk);
        out_ready = !(c >= 3 && c <= 6);
        in_valid  = (idx < 5);
        if (idx < 5) begin
          mul1 = bp_a[idx];
          mul2 = bp_b[idx];
        end
        #1;
        if (c >= 3 && c <= 6) begin
          chk("bp in_ready stalled", 32'(in_ready), 32'd0);
          chk("bp hold valid", 32'(out_valid), 32'd1);
          chk("bp hold data", obs(), bp_e[oidx]);
        end else if (c < 3) begin
          chk("bp in_ready free", 32'(in_ready), 32'd1);
        end
        if (out_valid && out_ready) begin
          chk("bp order", obs(), bp_e[oidx]);
          oidx++;
        end
        if (in_valid && in_ready) idx++;
      end
      chk("bp accepted", 32'(idx), 32'd5);
      chk("bp emitted", 32'(oidx), 32'd5);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        #1 chk("bp no dup", 32'(out_valid), 32'd0);
      end
    end

    // Half precision: 1.0 x 2.0
    @(negedge clk);
    h_mul1 = 16'h3C00; h_mul2 = 16'h4000; h_in_valid = 1'b1;
    @(negedge clk);
    h_in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("half valid", 32'(h_out_valid), 32'd1);
    chk("half exp", 32'(int'(h_result_exp)), 32'd16);
    chk("half flags", {26'b0, h_result_sign,
                       h_res_nan, h_res_inf, h_res_zero, h_exp_ovf, h_exp_unf}, 32'd0);

    // Reset with two items in flight
    @(negedge clk);
    out_ready = 1'b0;
    mul1 = 32'h40000000; mul2 = 32'h40000000; in_valid = 1'b1;
    @(negedge clk);
    mul1 = 32'h3F800000; mul2 = 32'hC0400000;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("inflight valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst valid", 32'(out_valid), 32'd0);
    chk("async rst payload", obs(), pack(1'b0, 0, 5'b0));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk("post-rst quiet", 32'(out_valid), 32'd0);
    end
    run_vec("after rst", 32'h40000000, 32'h40000000, 1'b0, 129, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
